// File: rtl/semaforo_temporizado.sv
// rtl/semaforo_temporizado.sv - timed traffic-light controller with pedestrian shortening and manual/fault modes
module semaforo_temporizado #(
    parameter int TICKS_PER_SEC = 50,
    parameter int CNT_BITS      = 4,
    parameter int T_PARE        = 5,
    parameter int T_SIGA        = 4,
    parameter int T_ATENCAO     = 2
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic                enable,
    input  logic                modo_manual,
    input  logic                man_pare,
    input  logic                man_atencao,
    input  logic                man_siga,
    input  logic                pedido_pedestre,
    output logic [2:0]          luz,
    output logic [7:0]          seg,
    output logic [CNT_BITS-1:0] restante,
    output logic                falha
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]       PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [CNT_BITS-1:0] LD_PARE    = CNT_BITS'(T_PARE);
    localparam logic [CNT_BITS-1:0] LD_SIGA    = CNT_BITS'(T_SIGA);
    localparam logic [CNT_BITS-1:0] LD_ATENCAO = CNT_BITS'(T_ATENCAO);
    localparam logic [CNT_BITS-1:0] ONE        = CNT_BITS'(1);

    localparam logic [7:0] SEG_PARE    = 8'b0111_0011;
    localparam logic [7:0] SEG_ATENCAO = 8'b0111_0111;
    localparam logic [7:0] SEG_SIGA    = 8'b0110_1101;

    typedef enum logic [2:0] {
        S_PARE,
        S_SIGA,
        S_ATENCAO,
        S_MANUAL,
        S_FALHA
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] restante_q, restante_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                pendente_q, pendente_d;
    logic                blink_q, blink_d;
    logic [2:0]          man_luz_q, man_luz_d;

    logic       tick;
    logic       entra_pare;
    logic [1:0] n_man;

    assign tick  = enable && (presc_q == PRESC_MAX);
    assign n_man = {1'b0, man_pare} + {1'b0, man_atencao} + {1'b0, man_siga};

    always_comb begin
        state_d    = state_q;
        restante_d = restante_q;
        presc_d    = presc_q;
        blink_d    = blink_q;
        man_luz_d  = man_luz_q;
        entra_pare = 1'b0;

        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // Manual decode and the manual exit ignore enable; only tick-driven work is frozen.
        if (modo_manual) begin
            if (n_man >= 2'd2) begin
                state_d = S_FALHA;
            end else begin
                state_d   = S_MANUAL;
                man_luz_d = {man_siga, man_atencao, man_pare};
            end
            if (tick && state_q == S_FALHA) begin
                blink_d = ~blink_q;
            end
        end else if (state_q == S_MANUAL || state_q == S_FALHA) begin
            state_d    = S_PARE;
            restante_d = LD_PARE;
            presc_d    = '0;
            blink_d    = 1'b0;
            entra_pare = 1'b1;
        end else if (tick) begin
            if (restante_q == ONE) begin
                case (state_q)
                    S_PARE: begin
                        state_d    = S_SIGA;
                        restante_d = LD_SIGA;
                    end
                    S_SIGA: begin
                        state_d    = S_ATENCAO;
                        restante_d = LD_ATENCAO;
                    end
                    default: begin
                        state_d    = S_PARE;
                        restante_d = LD_PARE;
                        entra_pare = 1'b1;
                    end
                endcase
            end else if (state_q == S_SIGA && pendente_q && restante_q > ONE) begin
                restante_d = ONE;
            end else begin
                restante_d = restante_q - ONE;
            end
        end

        // A request on the PARE-entry cycle outranks the clear.
        pendente_d = entra_pare ? 1'b0 : pendente_q;
        if (pedido_pedestre) begin
            pendente_d = 1'b1;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q    <= S_PARE;
            restante_q <= LD_PARE;
            presc_q    <= '0;
            pendente_q <= 1'b0;
            blink_q    <= 1'b0;
            man_luz_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            restante_q <= restante_d;
            presc_q    <= presc_d;
            pendente_q <= pendente_d;
            blink_q    <= blink_d;
            man_luz_q  <= man_luz_d;
        end
    end

    always_comb begin
        luz   = 3'b001;
        seg   = SEG_PARE;
        falha = 1'b0;
        case (state_q)
            S_PARE: begin
                luz = 3'b001;
                seg = SEG_PARE;
            end
            S_SIGA: begin
                luz = 3'b100;
                seg = SEG_SIGA;
            end
            S_ATENCAO: begin
                luz = 3'b010;
                seg = SEG_ATENCAO;
            end
            S_MANUAL: begin
                luz = man_luz_q;
                case (man_luz_q)
                    3'b001:  seg = SEG_PARE;
                    3'b010:  seg = SEG_ATENCAO;
                    3'b100:  seg = SEG_SIGA;
                    default: seg = 8'h00;
                endcase
            end
            S_FALHA: begin
                luz   = {1'b0, blink_q, 1'b0};
                seg   = 8'hFF;
                falha = 1'b1;
            end
            default: begin
                luz = 3'b001;
                seg = SEG_PARE;
            end
        endcase
    end

    assign restante = restante_q;

endmodule

// File: tb/tb_semaforo_temporizado.sv
// tb/tb_semaforo_temporizado.sv - directed and randomized checks of semaforo_temporizado against a phase-table model
module tb_semaforo_temporizado;

    localparam int TPS = 4;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       enable;
    logic       modo_manual;
    logic       man_pare;
    logic       man_atencao;
    logic       man_siga;
    logic       pedido_pedestre;
    logic [2:0] luz;
    logic [7:0] seg;
    logic [3:0] restante;
    logic       falha;

    int checks   = 0;
    int failures = 0;

    semaforo_temporizado #(
        .TICKS_PER_SEC(TPS),
        .CNT_BITS     (4),
        .T_PARE       (5),
        .T_SIGA       (4),
        .T_ATENCAO    (2)
    ) dut (
        .clk_2          (clk_2),
        .reset          (reset),
        .enable         (enable),
        .modo_manual    (modo_manual),
        .man_pare       (man_pare),
        .man_atencao    (man_atencao),
        .man_siga       (man_siga),
        .pedido_pedestre(pedido_pedestre),
        .luz            (luz),
        .seg            (seg),
        .restante       (restante),
        .falha          (falha)
    );

    always #5 clk_2 = ~clk_2;

    // Phase numbers: 0 PARE, 1 SIGA, 2 ATENCAO (automatic ring), 3 MANUAL, 4 FALHA.
    int   dur_of  [3] = '{5, 4, 2};
    logic [2:0] lamp_of [3] = '{3'b001, 3'b100, 3'b010};
    logic [7:0] code_of [3] = '{8'h73, 8'h6D, 8'h77};

    int   m_ph, m_rem, m_pre;
    bit   m_pend, m_blk;
    logic [2:0] m_lamp;

    task automatic model_reset();
        m_ph = 0; m_rem = 5; m_pre = 0; m_pend = 0; m_blk = 0; m_lamp = 3'b000;
    endtask

    task automatic model_step();
        bit tick, ent;
        int nph, nrem, npre, nman;
        bit nblk;
        logic [2:0] nlamp;
        tick = enable && (m_pre == TPS - 1);
        nph = m_ph; nrem = m_rem; npre = m_pre; nblk = m_blk; nlamp = m_lamp; ent = 0;
        if (enable) npre = tick ? 0 : m_pre + 1;
        nman = int'(man_pare) + int'(man_atencao) + int'(man_siga);
        if (modo_manual) begin
            if (nman >= 2) nph = 4;
            else begin
                nph = 3;
                nlamp = {man_siga, man_atencao, man_pare};
            end
            if (tick && m_ph == 4) nblk = !m_blk;
        end else if (m_ph >= 3) begin
            nph = 0; nrem = dur_of[0]; npre = 0; nblk = 0; ent = 1;
        end else if (tick) begin
            if (m_rem == 1) begin
                nph  = (m_ph + 1) % 3;
                nrem = dur_of[nph];
                ent  = (nph == 0);
            end else if (m_ph == 1 && m_pend) nrem = 1;
            else nrem = m_rem - 1;
        end
        m_pend = (ent ? 1'b0 : m_pend) | pedido_pedestre;
        m_ph = nph; m_rem = nrem; m_pre = npre; m_blk = nblk; m_lamp = nlamp;
    endtask

    task automatic chk(input string tag);
        logic [2:0] e_luz;
        logic [7:0] e_seg;
        logic       e_falha;
        e_falha = 1'b0;
        if (m_ph < 3) begin
            e_luz = lamp_of[m_ph];
            e_seg = code_of[m_ph];
        end else if (m_ph == 3) begin
            e_luz = m_lamp;
            e_seg = 8'h00;
            for (int k = 0; k < 3; k++) if (lamp_of[k] == m_lamp) e_seg = code_of[k];
        end else begin
            e_luz   = {1'b0, m_blk, 1'b0};
            e_seg   = 8'hFF;
            e_falha = 1'b1;
        end
        checks += 4;
        assert (luz === e_luz) else begin
            failures++; $error("FAIL %s luz got=%b exp=%b", tag, luz, e_luz);
        end
        assert (seg === e_seg) else begin
            failures++; $error("FAIL %s seg got=%h exp=%h", tag, seg, e_seg);
        end
        assert (restante === 4'(m_rem)) else begin
            failures++; $error("FAIL %s restante got=%0d exp=%0d", tag, restante, m_rem);
        end
        assert (falha === e_falha) else begin
            failures++; $error("FAIL %s falha got=%b exp=%b", tag, falha, e_falha);
        end
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk_2);
        #1;
        chk(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        checks++;
        assert (luz === 3'b001 && seg === 8'b0111_0011 && restante === 4'd5 && falha === 1'b0) else begin
            failures++;
            $error("FAIL %s got luz=%b seg=%h restante=%0d falha=%b exp luz=001 seg=73 restante=5 falha=0",
                   tag, luz, seg, restante, falha);
        end
    endtask

    initial begin
        int siga_cycles;
        int i;
        reset = 1'b1; enable = 1'b1; modo_manual = 1'b0;
        man_pare = 1'b0; man_atencao = 1'b0; man_siga = 1'b0; pedido_pedestre = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_2);
        #1;
        chk_reset_vals("reset_state");
        reset = 1'b0;

        for (int k = 0; k < 44; k++) cyc("auto_cycle");

        pedido_pedestre = 1'b1;
        cyc("ped_pulse");
        pedido_pedestre = 1'b0;
        siga_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            cyc("ped_short");
            if (luz === 3'b100) siga_cycles++;
        end
        checks++;
        assert (siga_cycles == 2 * TPS) else begin
            failures++; $error("FAIL ped_siga_len got=%0d exp=%0d", siga_cycles, 2 * TPS);
        end
        for (int k = 0; k < 44; k++) cyc("after_ped");

        modo_manual = 1'b1; man_siga = 1'b1;
        cyc("man_siga");
        man_pare = 1'b1;
        for (int k = 0; k < 12; k++) cyc("man_falha");
        man_pare = 1'b0; man_siga = 1'b0;
        for (int k = 0; k < 3; k++) cyc("man_off");
        modo_manual = 1'b0;
        for (int k = 0; k < 10; k++) cyc("man_exit");

        i = 0;
        while (i < 100 && !(m_ph == 1 && m_rem == 3)) begin
            cyc("seek_siga3");
            i++;
        end
        checks++;
        assert (m_ph == 1 && m_rem == 3) else begin
            failures++; $error("FAIL seek_siga3 timeout got_ph=%0d exp_ph=1", m_ph);
        end
        enable = 1'b0;
        for (int k = 0; k < 10; k++) cyc("frozen");
        enable = 1'b1;
        for (int k = 0; k < 20; k++) cyc("resume");

        for (int k = 0; k < 600; k++) begin
            if (k % 40 == 0) modo_manual = ($urandom_range(0, 2) == 0);
            man_pare        = ($urandom_range(0, 2) == 0);
            man_atencao     = ($urandom_range(0, 2) == 0);
            man_siga        = ($urandom_range(0, 2) == 0);
            enable          = ($urandom_range(0, 7) != 0);
            pedido_pedestre = ($urandom_range(0, 15) == 0);
            cyc("random");
        end
        modo_manual = 1'b0; enable = 1'b1; pedido_pedestre = 1'b0;
        man_pare = 1'b0; man_atencao = 1'b0; man_siga = 1'b0;

        i = 0;
        while (i < 100 && m_ph != 2) begin
            cyc("seek_atencao");
            i++;
        end
        checks++;
        assert (m_ph == 2) else begin
            failures++; $error("FAIL seek_atencao timeout got_ph=%0d exp_ph=2", m_ph);
        end
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        model_reset();
        @(posedge clk_2);
        #1;
        chk("reset_hold");
        reset = 1'b0;
        for (int k = 0; k < 25; k++) cyc("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
